// File: rtl/seq_playback_pkg.sv
// Shared game definitions: playback state encoding, blank display code and
// the RAM geometry defaults that the sequencer and game controller also use.
package seq_playback_pkg;

    localparam int         ADDR_W_DEF     = 5;
    localparam int         DATA_W_DEF     = 4;
    localparam logic [3:0] BLANK_CODE_DEF = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHOW  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } pb_state_e;

    // States in which the two-second timer must be running.
    function automatic logic is_timed_state(input pb_state_e s);
        return (s == ST_SHOW) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/seq_playback.sv
// Sequence playback: reads the stored digit sequence from the sequence RAM
// and shows each digit for SHOW_TICKS timer ticks followed by a blank gap of
// GAP_TICKS ticks, then pulses done. All outputs are registered.
module seq_playback
    import seq_playback_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                SHOW_TICKS = 1,
    parameter int                GAP_TICKS  = 1,
    parameter logic [DATA_W-1:0] BLANK_CODE = DATA_W'(BLANK_CODE_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] seq_len,
    input  logic              tick,
    input  logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] disp_digit,
    output logic              tick_en,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0]        SHOW_T   = 4'(SHOW_TICKS);
    localparam logic [3:0]        GAP_T    = 4'(GAP_TICKS);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    pb_state_e         r_state;
    pb_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_len_q;
    logic [ADDR_W-1:0] r_idx;
    logic [3:0]        r_tcnt;
    logic [3:0]        w_tcnt_inc;
    logic              w_show_hit;
    logic              w_gap_hit;
    logic              w_last_digit;

    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_disp;
    logic              r_tick_en;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] w_addr_d;
    logic [DATA_W-1:0] w_disp_d;
    logic              w_tick_en_d;
    logic              w_busy_d;
    logic              w_done_d;

    assign w_tcnt_inc   = r_tcnt + 4'd1;
    assign w_show_hit   = tick && (w_tcnt_inc == SHOW_T);
    assign w_gap_hit    = tick && (w_tcnt_inc == GAP_T);
    assign w_last_digit = (r_idx == (r_len_q - ADDR_ONE));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides every other event.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (seq_len == {ADDR_W{1'b0}}) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_FETCH;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_FETCH: w_state_nxt = ST_WAIT;
                ST_WAIT:  w_state_nxt = ST_SHOW;
                ST_SHOW: begin
                    if (w_show_hit) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_SHOW;
                    end
                end
                ST_GAP: begin
                    if (w_gap_hit) begin
                        if (w_last_digit) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_FETCH;
                        end
                    end else begin
                        w_state_nxt = ST_GAP;
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs, looking ahead at the next state.
    always_comb begin
        w_done_d    = (r_state == ST_DONE) && !abort;
        w_busy_d    = (w_state_nxt != ST_IDLE) || w_done_d;
        w_tick_en_d = is_timed_state(w_state_nxt);

        if (w_state_nxt == ST_SHOW) begin
            if (r_state == ST_WAIT) begin
                w_disp_d = ram_data;
            end else begin
                w_disp_d = r_disp;
            end
        end else begin
            w_disp_d = BLANK_CODE;
        end

        if (w_state_nxt == ST_IDLE) begin
            w_addr_d = {ADDR_W{1'b0}};
        end else if ((w_state_nxt == ST_FETCH) && (r_state == ST_GAP)) begin
            w_addr_d = r_idx + ADDR_ONE;
        end else if (w_state_nxt == ST_FETCH) begin
            w_addr_d = {ADDR_W{1'b0}};
        end else begin
            w_addr_d = r_ram_addr;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ram_addr <= {ADDR_W{1'b0}};
            r_disp     <= BLANK_CODE;
            r_tick_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ram_addr <= w_addr_d;
            r_disp     <= w_disp_d;
            r_tick_en  <= w_tick_en_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
        end
    end

    // Sequence length, digit index and tick counter; ticks outside SHOW/GAP are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len_q <= {ADDR_W{1'b0}};
            r_idx   <= {ADDR_W{1'b0}};
            r_tcnt  <= 4'd0;
        end else if (abort) begin
            r_tcnt <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len_q <= seq_len;
                        r_idx   <= {ADDR_W{1'b0}};
                        r_tcnt  <= 4'd0;
                    end
                end
                ST_WAIT: r_tcnt <= 4'd0;
                ST_SHOW: begin
                    if (tick) begin
                        r_tcnt <= w_show_hit ? 4'd0 : w_tcnt_inc;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (w_gap_hit) begin
                            r_tcnt <= 4'd0;
                            if (!w_last_digit) begin
                                r_idx <= r_idx + ADDR_ONE;
                            end
                        end else begin
                            r_tcnt <= w_tcnt_inc;
                        end
                    end
                end
                default: r_tcnt <= r_tcnt;
            endcase
        end
    end

    assign ram_addr   = r_ram_addr;
    assign disp_digit = r_disp;
    assign tick_en    = r_tick_en;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_seq_playback.sv
// Directed testbench for seq_playback (SHOW_TICKS=2, GAP_TICKS=3).
module tb_seq_playback;

    localparam logic [3:0] BLANK = 4'hF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] seq_len = 5'd0;
    logic       tick = 1'b0;
    logic [3:0] ram_data = 4'h0;
    logic [4:0] ram_addr;
    logic [3:0] disp_digit;
    logic       tick_en;
    logic       busy;
    logic       done;

    logic [3:0] mem [32];

    int checks = 0;
    int failures = 0;

    // playback recorder results
    logic [31:0] disp_sig;
    logic [31:0] addr_sig;
    int          disp_cnt;
    int          addr_cnt;
    int          done_cnt;
    int          done_lat;
    logic [4:0]  addr_last;
    logic        busy_at_done;
    logic        busy_after_done;

    seq_playback #(
        .ADDR_W(5), .DATA_W(4), .SHOW_TICKS(2), .GAP_TICKS(3), .BLANK_CODE(4'hF)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seq_len(seq_len),
        .tick(tick), .ram_data(ram_data), .ram_addr(ram_addr),
        .disp_digit(disp_digit), .tick_en(tick_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // synchronous-read sequence RAM model
    always @(posedge clk) ram_data <= mem[ram_addr];

    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] len);
        start = 1'b1;
        seq_len = len;
        step(1'b0);
        start = 1'b0;
    endtask

    // Runs with a tick every `period` cycles, logging display changes and done.
    task automatic run_play(input int period, input int max_cyc);
        logic [3:0] prev;
        int last_tick;
        int post;
        bit seen;
        prev = disp_digit;
        disp_sig = 32'd0; addr_sig = 32'd0; disp_cnt = 0; addr_cnt = 0;
        done_cnt = 0; done_lat = -1; addr_last = 5'd0;
        busy_at_done = 1'b0; busy_after_done = 1'b1;
        last_tick = -100; post = 0; seen = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            tick = ((c % period) == (period - 1));
            @(posedge clk);
            #1;
            if (tick && !seen) last_tick = c;
            tick = 1'b0;
            if (disp_digit !== prev) begin
                disp_sig = {disp_sig[27:0], disp_digit};
                disp_cnt++;
                if (disp_digit !== BLANK) begin
                    addr_sig = {addr_sig[23:0], 3'b000, ram_addr};
                    addr_cnt++;
                    addr_last = ram_addr;
                end
                prev = disp_digit;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (!seen) begin
                    done_lat = c - last_tick;
                    busy_at_done = busy;
                end
                seen = 1'b1;
            end else if (seen) begin
                post++;
                if (post == 1) busy_after_done = busy;
                if (post >= 2) break;
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(1'b0);
        step(1'b0);
        checks++; if (ram_addr !== 5'd0) begin $display("FAIL reset_addr: got %0d expected 0", ram_addr); failures++; end
        checks++; if (disp_digit !== BLANK) begin $display("FAIL reset_disp: got %0h expected f", disp_digit); failures++; end
        checks++; if ({tick_en, busy, done} !== 3'b000) begin $display("FAIL reset_flags: got %b expected 000", {tick_en, busy, done}); failures++; end
        rst = 1'b1;
        step(1'b0);
    endtask

    task automatic test_basic();
        mem[0] = 4'h3; mem[1] = 4'h7; mem[2] = 4'h1;
        pulse_start(5'd3);
        checks++; if ({busy, tick_en, ram_addr} !== {1'b1, 1'b0, 5'd0}) begin $display("FAIL basic_k: busy/tick_en/addr got %b/%b/%0d expected 1/0/0", busy, tick_en, ram_addr); failures++; end
        step(1'b0);
        checks++; if (disp_digit !== BLANK) begin $display("FAIL basic_k1_disp: got %0h expected f", disp_digit); failures++; end
        step(1'b0);
        checks++; if ({disp_digit, tick_en} !== {4'h3, 1'b1}) begin $display("FAIL basic_k2: disp/tick_en got %0h/%b expected 3/1", disp_digit, tick_en); failures++; end
        run_play(10, 1000);
        checks++; if ({disp_cnt[7:0], disp_sig} !== {8'd5, 32'h000F7F1F}) begin $display("FAIL basic_disp_seq: got n=%0d %h expected n=5 000f7f1f", disp_cnt, disp_sig); failures++; end
        checks++; if ({addr_cnt[7:0], addr_sig} !== {8'd2, 32'h00000102}) begin $display("FAIL basic_addr_seq: got n=%0d %h expected n=2 00000102", addr_cnt, addr_sig); failures++; end
        checks++; if (done_cnt !== 1) begin $display("FAIL basic_done_count: got %0d expected 1", done_cnt); failures++; end
        checks++; if (done_lat !== 1) begin $display("FAIL basic_done_latency: got %0d expected 1", done_lat); failures++; end
        checks++; if ({busy_at_done, busy_after_done} !== 2'b10) begin $display("FAIL basic_busy_fall: got %b expected 10", {busy_at_done, busy_after_done}); failures++; end
        checks++; if ({ram_addr, disp_digit} !== {5'd0, BLANK}) begin $display("FAIL basic_idle: addr/disp got %0d/%0h expected 0/f", ram_addr, disp_digit); failures++; end
    endtask

    task automatic test_zero_len();
        pulse_start(5'd0);
        checks++; if ({busy, done, tick_en, ram_addr} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin $display("FAIL zero_k: got %b expected 10000000", {busy, done, tick_en, ram_addr}); failures++; end
        step(1'b0);
        checks++; if ({busy, done, tick_en, ram_addr} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin $display("FAIL zero_k1: got %b expected 11000000", {busy, done, tick_en, ram_addr}); failures++; end
        step(1'b0);
        checks++; if ({busy, done, tick_en, disp_digit} !== {1'b0, 1'b0, 1'b0, BLANK}) begin $display("FAIL zero_k2: got %b expected 0001111", {busy, done, tick_en, disp_digit}); failures++; end
    endtask

    task automatic test_abort();
        bit found;
        bit bad;
        mem[0] = 4'h2; mem[1] = 4'h4; mem[2] = 4'h6; mem[3] = 4'h8; mem[4] = 4'h9;
        pulse_start(5'd5);
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            step((c % 10) == 9);
            if (disp_digit === 4'h4) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin $display("FAIL abort_reach_digit2: got timeout expected digit 4 shown"); failures++; end
        abort = 1'b1;
        step(1'b1);
        abort = 1'b0;
        checks++; if ({disp_digit, busy, tick_en, done, ram_addr} !== {BLANK, 3'b000, 5'd0}) begin $display("FAIL abort_idle: disp/busy/tick_en/done/addr got %0h/%b/%b/%b/%0d expected f/0/0/0/0", disp_digit, busy, tick_en, done, ram_addr); failures++; end
        bad = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step((c % 10) == 9);
            if (done !== 1'b0 || disp_digit !== BLANK || busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin $display("FAIL abort_quiet: got activity after abort expected none"); failures++; end
        pulse_start(5'd5);
        step(1'b0);
        step(1'b0);
        checks++; if ({disp_digit, ram_addr} !== {4'h2, 5'd0}) begin $display("FAIL abort_replay: disp/addr got %0h/%0d expected 2/0", disp_digit, ram_addr); failures++; end
        run_play(10, 2000);
        checks++; if ({done_cnt[7:0], addr_cnt[7:0], addr_last} !== {8'd1, 8'd4, 5'd4}) begin $display("FAIL abort_replay_end: done/n/last got %0d/%0d/%0d expected 1/4/4", done_cnt, addr_cnt, addr_last); failures++; end
    endtask

    task automatic test_back_to_back();
        mem[0] = 4'h3; mem[1] = 4'h7; mem[2] = 4'h1; mem[3] = 4'h5; mem[4] = 4'h6;
        pulse_start(5'd3);
        step(1'b0);
        step(1'b0);
        start = 1'b1; seq_len = 5'd5;
        step(1'b0);
        start = 1'b0; seq_len = 5'd3;
        run_play(10, 1000);
        checks++; if ({addr_cnt[7:0], addr_sig} !== {8'd2, 32'h00000102}) begin $display("FAIL restart_addr_seq: got n=%0d %h expected n=2 00000102", addr_cnt, addr_sig); failures++; end
        checks++; if (done_cnt !== 1) begin $display("FAIL restart_done_count: got %0d expected 1", done_cnt); failures++; end
    endtask

    task automatic test_tick_ignore();
        mem[0] = 4'h9;
        start = 1'b1; seq_len = 5'd1;
        step(1'b1);
        start = 1'b0;
        step(1'b1);
        step(1'b1);
        checks++; if ({disp_digit, tick_en} !== {4'h9, 1'b1}) begin $display("FAIL tick_show_entry: disp/tick_en got %0h/%b expected 9/1", disp_digit, tick_en); failures++; end
        for (int c = 0; c < 4; c++) step(1'b0);
        step(1'b1);
        checks++; if (disp_digit !== 4'h9) begin $display("FAIL tick_show_one: got %0h expected 9", disp_digit); failures++; end
        step(1'b1);
        checks++; if ({disp_digit, tick_en} !== {BLANK, 1'b1}) begin $display("FAIL tick_show_two: disp/tick_en got %0h/%b expected f/1", disp_digit, tick_en); failures++; end
        step(1'b1);
        step(1'b1);
        checks++; if ({busy, done} !== 2'b10) begin $display("FAIL tick_gap_two: busy/done got %b expected 10", {busy, done}); failures++; end
        step(1'b1);
        checks++; if (done !== 1'b0) begin $display("FAIL tick_gap_three: done got %b expected 0", done); failures++; end
        step(1'b0);
        checks++; if ({done, tick_en} !== 2'b10) begin $display("FAIL tick_done: done/tick_en got %b expected 10", {done, tick_en}); failures++; end
        step(1'b0);
    endtask

    task automatic test_async_reset_and_max();
        bit found;
        bit saw7;
        mem[0] = 4'h3; mem[1] = 4'h7; mem[2] = 4'h1;
        pulse_start(5'd3);
        found = 1'b0; saw7 = 1'b0;
        for (int c = 0; c < 300; c++) begin
            step((c % 10) == 9);
            if (disp_digit === 4'h7) saw7 = 1'b1;
            if (saw7 && disp_digit === BLANK && tick_en === 1'b1) begin found = 1'b1; break; end
        end
        checks++; if (!found || ram_addr !== 5'd1) begin $display("FAIL areset_reach_gap: found/addr got %b/%0d expected 1/1", found, ram_addr); failures++; end
        #2 rst = 1'b0;
        #1;
        checks++; if ({ram_addr, disp_digit, tick_en, busy, done} !== {5'd0, BLANK, 3'b000}) begin $display("FAIL areset_immediate: addr/disp/flags got %0d/%0h/%b expected 0/f/000", ram_addr, disp_digit, {tick_en, busy, done}); failures++; end
        @(posedge clk);
        #1 rst = 1'b1;
        step(1'b0);
        for (int i = 0; i < 32; i++) mem[i] = 4'(i % 15);
        pulse_start(5'd31);
        run_play(10, 4000);
        checks++; if ({done_cnt[7:0], addr_cnt[7:0], addr_last} !== {8'd1, 8'd31, 5'd30}) begin $display("FAIL max_len: done/n/last got %0d/%0d/%0d expected 1/31/30", done_cnt, addr_cnt, addr_last); failures++; end
        checks++; if ({disp_cnt[7:0], disp_sig[15:0]} !== {8'd62, 16'hEF0F}) begin $display("FAIL max_len_disp: got n=%0d %h expected n=62 ef0f", disp_cnt, disp_sig[15:0]); failures++; end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 4'h0;
        test_reset();
        test_basic();
        test_zero_len();
        test_abort();
        test_back_to_back();
        test_tick_ignore();
        test_async_reset_and_max();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
